// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the central sequencer.
// The pipeline (master) raises requests; the sequencer (slave) answers with stall/flush/redirect/trap.
interface pipe_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        branch_req_i;
    logic [31:0] branch_tgt_i;
    logic        excp_req_i;
    logic [3:0]  excp_cause_i;
    logic [31:0] excp_pc_i;
    logic [31:0] mtvec_i;
    logic [5:0]  stalled;
    logic [5:0]  flush;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        excp_valid_o;
    logic [3:0]  excp_cause_o;
    logic [31:0] excp_epc_o;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output branch_req_i, branch_tgt_i,
        output excp_req_i, excp_cause_i, excp_pc_i, mtvec_i,
        input  stalled, flush, redirect_o, redirect_pc_o,
        input  excp_valid_o, excp_cause_o, excp_epc_o
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  branch_req_i, branch_tgt_i,
        input  excp_req_i, excp_cause_i, excp_pc_i, mtvec_i,
        output stalled, flush, redirect_o, redirect_pc_o,
        output excp_valid_o, excp_cause_o, excp_epc_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: merges stall requests, EX branch redirects and MEM exceptions
// into the stall/flush vectors and PC redirect, deferring redirects while a fetch is in flight.
module pipe_ctrl #(
    parameter int          MEM_TIMEOUT   = 256,
    parameter int          CNT_W         = 9,
    parameter logic [3:0]  TIMEOUT_CAUSE = 4'hB
) (
    input logic       clk,
    input logic       rst,
    pipe_ctrl_if.slave bus
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       tgt_q, tgt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [5:0]  base_stall;
    logic        timeout_hit;
    logic        take_excp;
    logic        branch_ok;

    logic [5:0]  stalled_c;
    logic [5:0]  flush_c;
    logic        redirect_c;
    logic [31:0] redirect_pc_c;
    logic        excp_valid_c;
    logic [3:0]  excp_cause_c;
    logic [31:0] excp_epc_c;

    // Stall the highest requesting stage and everything upstream of it.
    always_comb begin
        base_stall = 6'b000000;
        if (bus.stallreq_mem) begin
            base_stall = 6'b011111;
        end else if (bus.stallreq_ex) begin
            base_stall = 6'b001111;
        end else if (bus.stallreq_id) begin
            base_stall = 6'b000111;
        end else if (bus.stallreq_if) begin
            base_stall = 6'b000011;
        end
    end

    // A branch is held by a frozen EX stage, so it only counts once EX can advance.
    always_comb begin
        timeout_hit = bus.stallreq_mem && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
        take_excp   = bus.excp_req_i || timeout_hit;
        branch_ok   = bus.branch_req_i && !bus.stallreq_ex && !bus.stallreq_mem;
    end

    always_comb begin
        cnt_d = '0;
        if (take_excp) begin
            cnt_d = '0;
        end else if (bus.stallreq_mem) begin
            cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        tgt_d         = tgt_q;
        stalled_c     = base_stall;
        flush_c       = 6'b000000;
        redirect_c    = 1'b0;
        redirect_pc_c = 32'h0;
        excp_valid_c  = 1'b0;
        excp_cause_c  = 4'h0;
        excp_epc_c    = 32'h0;

        if (take_excp) begin
            stalled_c     = 6'b000000;
            flush_c       = 6'b011111;
            redirect_c    = 1'b1;
            redirect_pc_c = bus.mtvec_i;
            excp_valid_c  = 1'b1;
            excp_cause_c  = bus.excp_req_i ? bus.excp_cause_i : TIMEOUT_CAUSE;
            excp_epc_c    = bus.excp_pc_i;
            state_d       = RUN;
        end else if (branch_ok) begin
            flush_c = 6'b000110;
            if (bus.stallreq_if) begin
                // Fetch still in flight: remember the target and redirect once it lands.
                stalled_c = 6'b000011;
                tgt_d     = bus.branch_tgt_i;
                state_d   = PEND;
            end else begin
                stalled_c     = 6'b000000;
                redirect_c    = 1'b1;
                redirect_pc_c = bus.branch_tgt_i;
                state_d       = RUN;
            end
        end else if (state_q == PEND) begin
            if (bus.stallreq_if) begin
                stalled_c = base_stall | 6'b000011;
            end else begin
                flush_c       = 6'b000010;
                redirect_c    = 1'b1;
                redirect_pc_c = tgt_q;
                state_d       = RUN;
            end
        end

        if (rst) begin
            stalled_c     = 6'b000000;
            flush_c       = 6'b000000;
            redirect_c    = 1'b0;
            redirect_pc_c = 32'h0;
            excp_valid_c  = 1'b0;
            excp_cause_c  = 4'h0;
            excp_epc_c    = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            tgt_q   <= 32'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stalled       = stalled_c;
    assign bus.flush         = flush_c;
    assign bus.redirect_o    = redirect_c;
    assign bus.redirect_pc_o = redirect_pc_c;
    assign bus.excp_valid_o  = excp_valid_c;
    assign bus.excp_cause_o  = excp_cause_c;
    assign bus.excp_epc_o    = excp_epc_c;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_pipe_ctrl;

    logic clk;
    logic rst;
    pipe_ctrl_if bus ();

    int n_vec;
    int n_err;

    pipe_ctrl #(
        .MEM_TIMEOUT   (256),
        .CNT_W         (9),
        .TIMEOUT_CAUSE (4'hB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        bus.stallreq_if  = 1'b0;
        bus.stallreq_id  = 1'b0;
        bus.stallreq_ex  = 1'b0;
        bus.stallreq_mem = 1'b0;
        bus.branch_req_i = 1'b0;
        bus.branch_tgt_i = 32'h0;
        bus.excp_req_i   = 1'b0;
        bus.excp_cause_i = 4'h0;
        bus.excp_pc_i    = 32'h0;
        bus.mtvec_i      = 32'h8000_0000;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        bus.branch_req_i = 1'b1;
        bus.branch_tgt_i = 32'h0000_0123;
        bus.excp_req_i   = 1'b1;
        advance();
        @(negedge clk);
        n_vec++;
        if (bus.stalled !== 6'b0 || bus.flush !== 6'b0) begin
            n_err++;
            $display("[TB] FAIL reset_vec stalled=%b flush=%b expected 000000/000000", bus.stalled, bus.flush);
        end
        n_vec++;
        if (bus.redirect_o !== 1'b0 || bus.redirect_pc_o !== 32'h0) begin
            n_err++;
            $display("[TB] FAIL reset_redir got %b/%h expected 0/00000000", bus.redirect_o, bus.redirect_pc_o);
        end
        n_vec++;
        if (bus.excp_valid_o !== 1'b0 || bus.excp_cause_o !== 4'h0 || bus.excp_epc_o !== 32'h0) begin
            n_err++;
            $display("[TB] FAIL reset_excp got %b/%h/%h expected 0/0/0", bus.excp_valid_o, bus.excp_cause_o, bus.excp_epc_o);
        end
        advance();
        drive_idle();
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.stalled !== 6'b0 || bus.redirect_o !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL post_reset_idle stalled=%b redir=%b expected 000000/0", bus.stalled, bus.redirect_o);
        end
        advance();
    endtask

    task automatic test_ex_stall();
        bus.stallreq_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.stalled !== 6'b001111 || bus.flush !== 6'b0) begin
                n_err++;
                $display("[TB] FAIL ex_stall[%0d] stalled=%b flush=%b expected 001111/000000", i, bus.stalled, bus.flush);
            end
            advance();
        end
        bus.stallreq_ex = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.stalled !== 6'b0) begin
            n_err++;
            $display("[TB] FAIL ex_stall_release stalled=%b expected 000000", bus.stalled);
        end
        advance();
    endtask

    task automatic test_branch();
        bus.branch_req_i = 1'b1;
        bus.branch_tgt_i = 32'h0000_0100;
        @(negedge clk);
        n_vec++;
        if (bus.flush !== 6'b000110 || bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h0000_0100 || bus.stalled !== 6'b0) begin
            n_err++;
            $display("[TB] FAIL branch_run flush=%b redir=%b pc=%h stalled=%b expected 000110/1/00000100/000000",
                     bus.flush, bus.redirect_o, bus.redirect_pc_o, bus.stalled);
        end
        advance();
        drive_idle();
        @(negedge clk);
        n_vec++;
        if (bus.redirect_o !== 1'b0 || bus.flush !== 6'b0) begin
            n_err++;
            $display("[TB] FAIL branch_pulse redir=%b flush=%b expected 0/000000", bus.redirect_o, bus.flush);
        end
        advance();
        bus.stallreq_ex  = 1'b1;
        bus.branch_req_i = 1'b1;
        bus.branch_tgt_i = 32'h0000_0DEA;
        @(negedge clk);
        n_vec++;
        if (bus.redirect_o !== 1'b0 || bus.flush !== 6'b0 || bus.stalled !== 6'b001111) begin
            n_err++;
            $display("[TB] FAIL branch_ex_frozen redir=%b flush=%b stalled=%b expected 0/000000/001111",
                     bus.redirect_o, bus.flush, bus.stalled);
        end
        advance();
        drive_idle();
        advance();
    endtask

    task automatic test_branch_pend();
        bus.stallreq_if  = 1'b1;
        bus.branch_req_i = 1'b1;
        bus.branch_tgt_i = 32'h0000_0200;
        @(negedge clk);
        n_vec++;
        if (bus.flush !== 6'b000110 || bus.redirect_o !== 1'b0 || bus.stalled !== 6'b000011) begin
            n_err++;
            $display("[TB] FAIL pend_enter flush=%b redir=%b stalled=%b expected 000110/0/000011",
                     bus.flush, bus.redirect_o, bus.stalled);
        end
        advance();
        bus.branch_req_i = 1'b0;
        bus.branch_tgt_i = 32'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.stalled !== 6'b000011 || bus.redirect_o !== 1'b0 || bus.flush !== 6'b0) begin
                n_err++;
                $display("[TB] FAIL pend_hold[%0d] stalled=%b redir=%b flush=%b expected 000011/0/000000",
                         i, bus.stalled, bus.redirect_o, bus.flush);
            end
            advance();
        end
        bus.stallreq_if = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h0000_0200 || bus.flush !== 6'b000010) begin
            n_err++;
            $display("[TB] FAIL pend_release redir=%b pc=%h flush=%b expected 1/00000200/000010",
                     bus.redirect_o, bus.redirect_pc_o, bus.flush);
        end
        advance();
        @(negedge clk);
        n_vec++;
        if (bus.redirect_o !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL pend_done redir=%b expected 0", bus.redirect_o);
        end
        advance();
    endtask

    task automatic test_timeout();
        bus.stallreq_mem = 1'b1;
        bus.excp_pc_i    = 32'h0000_0044;
        bus.mtvec_i      = 32'h8000_0040;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            n_vec++;
            if (i < 256) begin
                if (bus.excp_valid_o !== 1'b0 || bus.stalled !== 6'b011111) begin
                    n_err++;
                    $display("[TB] FAIL timeout_wait[%0d] valid=%b stalled=%b expected 0/011111",
                             i, bus.excp_valid_o, bus.stalled);
                end
            end else begin
                if (bus.excp_valid_o !== 1'b1 || bus.excp_cause_o !== 4'hB || bus.excp_epc_o !== 32'h0000_0044 ||
                    bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h8000_0040 ||
                    bus.flush !== 6'b011111 || bus.stalled !== 6'b0) begin
                    n_err++;
                    $display("[TB] FAIL timeout_fire valid=%b cause=%h epc=%h redir=%b pc=%h flush=%b stalled=%b expected 1/b/00000044/1/80000040/011111/000000",
                             bus.excp_valid_o, bus.excp_cause_o, bus.excp_epc_o, bus.redirect_o,
                             bus.redirect_pc_o, bus.flush, bus.stalled);
                end
            end
            advance();
        end
        @(negedge clk);
        n_vec++;
        if (bus.excp_valid_o !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL timeout_restart valid=%b expected 0", bus.excp_valid_o);
        end
        advance();
        drive_idle();
        advance();
    endtask

    task automatic test_excp_priority();
        bus.excp_req_i   = 1'b1;
        bus.excp_cause_i = 4'h5;
        bus.excp_pc_i    = 32'h0000_1230;
        bus.branch_req_i = 1'b1;
        bus.branch_tgt_i = 32'h0000_0300;
        bus.stallreq_id  = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.redirect_pc_o !== 32'h8000_0000 || bus.excp_valid_o !== 1'b1 || bus.excp_cause_o !== 4'h5 ||
            bus.flush !== 6'b011111 || bus.stalled !== 6'b0 || bus.excp_epc_o !== 32'h0000_1230) begin
            n_err++;
            $display("[TB] FAIL excp_over_branch pc=%h valid=%b cause=%h flush=%b stalled=%b epc=%h expected 80000000/1/5/011111/000000/00001230",
                     bus.redirect_pc_o, bus.excp_valid_o, bus.excp_cause_o, bus.flush, bus.stalled, bus.excp_epc_o);
        end
        advance();
        drive_idle();
        bus.stallreq_if  = 1'b1;
        bus.branch_req_i = 1'b1;
        bus.branch_tgt_i = 32'h0000_0400;
        advance();
        bus.branch_req_i = 1'b0;
        bus.excp_req_i   = 1'b1;
        bus.excp_cause_i = 4'h2;
        @(negedge clk);
        n_vec++;
        if (bus.excp_valid_o !== 1'b1 || bus.redirect_pc_o !== 32'h8000_0000) begin
            n_err++;
            $display("[TB] FAIL excp_in_pend valid=%b pc=%h expected 1/80000000", bus.excp_valid_o, bus.redirect_pc_o);
        end
        advance();
        bus.excp_req_i  = 1'b0;
        bus.stallreq_if = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.redirect_o !== 1'b0 || bus.flush !== 6'b0) begin
            n_err++;
            $display("[TB] FAIL pend_discarded redir=%b flush=%b expected 0/000000", bus.redirect_o, bus.flush);
        end
        advance();
    endtask

    task automatic test_rst_in_pend();
        bus.stallreq_if  = 1'b1;
        bus.branch_req_i = 1'b1;
        bus.branch_tgt_i = 32'h0000_0500;
        advance();
        bus.branch_req_i = 1'b0;
        rst = 1'b1;
        advance();
        rst = 1'b0;
        bus.stallreq_if = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.redirect_o !== 1'b0 || bus.stalled !== 6'b0) begin
            n_err++;
            $display("[TB] FAIL rst_in_pend redir=%b stalled=%b expected 0/000000", bus.redirect_o, bus.stalled);
        end
        advance();
    endtask

    // Rule-level model: a pending flag/target, and a count of consecutive MEM stall cycles.
    task automatic test_random();
        bit          m_pend;
        logic [31:0] m_tgt;
        int          m_cnt;
        logic [5:0]  e_stalled, e_flush;
        logic        e_redir, e_valid;
        logic [31:0] e_pc, e_epc;
        logic [3:0]  e_cause;
        int          top;
        bit          r_if, r_id, r_ex, r_mem, r_br, r_ex_req, r_rst, trap;

        m_pend = 0;
        m_tgt  = 32'h0;
        m_cnt  = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            r_rst    = (cyc == 0) || ($urandom_range(0, 99) < 2);
            r_if     = $urandom_range(0, 99) < 35;
            r_id     = $urandom_range(0, 99) < 15;
            r_ex     = $urandom_range(0, 99) < 10;
            r_mem    = $urandom_range(0, 99) < 15;
            r_br     = $urandom_range(0, 99) < 20;
            r_ex_req = $urandom_range(0, 99) < 4;
            rst              = r_rst;
            bus.stallreq_if  = r_if;
            bus.stallreq_id  = r_id;
            bus.stallreq_ex  = r_ex;
            bus.stallreq_mem = r_mem;
            bus.branch_req_i = r_br;
            bus.branch_tgt_i = $urandom() & 32'hFFFF_FFFC;
            bus.excp_req_i   = r_ex_req;
            bus.excp_cause_i = 4'($urandom_range(0, 15));
            bus.excp_pc_i    = $urandom();
            bus.mtvec_i      = $urandom() & 32'hFFFF_FF00;

            e_stalled = 6'b0; e_flush = 6'b0; e_redir = 1'b0; e_pc = 32'h0;
            e_valid = 1'b0; e_cause = 4'h0; e_epc = 32'h0;
            if (r_rst) begin
                m_pend = 0;
                m_tgt  = 32'h0;
                m_cnt  = 0;
            end else begin
                top = r_mem ? 4 : r_ex ? 3 : r_id ? 2 : r_if ? 1 : 0;
                e_stalled = (top == 0) ? 6'b0 : 6'((1 << (top + 1)) - 1);
                trap = r_ex_req || (r_mem && m_cnt == 255);
                if (trap) begin
                    e_stalled = 6'b0;
                    e_flush   = 6'b011111;
                    e_redir   = 1'b1;
                    e_pc      = bus.mtvec_i;
                    e_valid   = 1'b1;
                    e_cause   = r_ex_req ? bus.excp_cause_i : 4'hB;
                    e_epc     = bus.excp_pc_i;
                    m_pend    = 0;
                    m_cnt     = 0;
                end else begin
                    m_cnt = r_mem ? ((m_cnt < 511) ? m_cnt + 1 : 511) : 0;
                    if (r_br && !r_ex && !r_mem) begin
                        e_flush = 6'b000110;
                        if (r_if) begin
                            e_stalled = 6'b000011;
                            m_pend    = 1;
                            m_tgt     = bus.branch_tgt_i;
                        end else begin
                            e_stalled = 6'b0;
                            e_redir   = 1'b1;
                            e_pc      = bus.branch_tgt_i;
                            m_pend    = 0;
                        end
                    end else if (m_pend) begin
                        if (r_if) begin
                            e_stalled = e_stalled | 6'b000011;
                        end else begin
                            e_flush = 6'b000010;
                            e_redir = 1'b1;
                            e_pc    = m_tgt;
                            m_pend  = 0;
                        end
                    end
                end
            end

            @(negedge clk);
            n_vec++;
            if (bus.stalled !== e_stalled) begin
                n_err++;
                $display("[TB] FAIL rand_stalled cyc=%0d got %b expected %b", cyc, bus.stalled, e_stalled);
            end
            n_vec++;
            if (bus.flush !== e_flush) begin
                n_err++;
                $display("[TB] FAIL rand_flush cyc=%0d got %b expected %b", cyc, bus.flush, e_flush);
            end
            n_vec++;
            if (bus.redirect_o !== e_redir || (e_redir && bus.redirect_pc_o !== e_pc)) begin
                n_err++;
                $display("[TB] FAIL rand_redirect cyc=%0d got %b/%h expected %b/%h", cyc, bus.redirect_o, bus.redirect_pc_o, e_redir, e_pc);
            end
            n_vec++;
            if (bus.excp_valid_o !== e_valid || (e_valid && (bus.excp_cause_o !== e_cause || bus.excp_epc_o !== e_epc))) begin
                n_err++;
                $display("[TB] FAIL rand_excp cyc=%0d got %b/%h/%h expected %b/%h/%h", cyc,
                         bus.excp_valid_o, bus.excp_cause_o, bus.excp_epc_o, e_valid, e_cause, e_epc);
            end
            advance();
        end
        rst = 1'b0;
        drive_idle();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        drive_idle();
        test_reset();
        test_ex_stall();
        test_branch();
        test_branch_pend();
        test_timeout();
        test_excp_priority();
        test_rst_in_pend();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
